mask_pixel_source: RTL and testbench



---
 rtl/mask_pkg.sv | 29 ++
 rtl/mask_pixel_source_if.sv | 37 +++
 rtl/pixel_skid_fifo.sv | 48 ++++
 rtl/mask_pixel_source.sv | 152 +++++++++++++++
 tb/tb_mask_pixel_source.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mask_pkg : mode encodings, RGB444 pixel type and the mask operation.
// Revision : 1.0
// ---------------------------------------------------------------------------
package mask_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_AND  = 2'd1;
  localparam logic [1:0] MODE_INV  = 2'd2;
  localparam logic [1:0] MODE_KEY  = 2'd3;

  typedef logic [11:0] rgb444_t;

  function automatic rgb444_t apply_mask(input logic [1:0] mode, input rgb444_t img,
                                         input logic m, input rgb444_t key);
    rgb444_t res;
    res = img;
    case (mode)
      MODE_AND: res = m ? img : 12'h000;
      MODE_INV: res = m ? ~img : img;
      MODE_KEY: res = m ? key : img;
      default:  res = img;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mask_pixel_source_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mask_pixel_source_if : control, memory and pixel-stream signals of the source.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mask_pixel_source_if #(
  parameter int ADDR_W = 15
);
  import mask_pkg::*;

  logic              start;
  logic [1:0]        mode;
  rgb444_t           key_colour;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  rgb444_t           img_data;
  logic              mask_data;
  logic              out_valid;
  logic              out_ready;
  rgb444_t           out_pixel;
  logic              out_sof;
  logic              out_eol;

  modport master (
    input  start, mode, key_colour, img_data, mask_data, out_ready,
    output busy, done, mem_addr, mem_rd, out_valid, out_pixel, out_sof, out_eol
  );

  modport slave (
    output start, mode, key_colour, img_data, mask_data, out_ready,
    input  busy, done, mem_addr, mem_rd, out_valid, out_pixel, out_sof, out_eol
  );

endinterface
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_skid_fifo : 2-entry FIFO absorbing read data while the sink stalls.
// Revision : 1.0
// ---------------------------------------------------------------------------
module pixel_skid_fifo #(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mask_pixel_source.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mask_pixel_source : raster-walks a stored frame, masks it, streams RGB444.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mask_pixel_source
  import mask_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  mask_pixel_source_if.master bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     LAST_X    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     LAST_Y    = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [1:0]        mode_q;
  rgb444_t           key_q;
  logic              inflight_q;
  logic              sof_tag_q;
  logic              eol_tag_q;
  logic              busy_q;
  logic              done_q;

  logic              w_rd;
  logic              w_accept;
  logic              w_finish;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [1:0]        w_occ;
  logic [2:0]        w_level;
  logic [13:0]       w_fifo_wdata;
  logic [13:0]       w_fifo_rdata;

  // Slots committed after this cycle: stored + returning - leaving. Keeping
  // this below 2 guarantees every returning word has a FIFO slot.
  assign w_pop   = w_fifo_valid && bus.out_ready;
  assign w_level = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_rd    = (state_q == RUN) && (w_level < 3'd2);

  always_comb begin
    state_d  = state_q;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q blocks a start arriving together with the done pulse
        if (bus.start && !done_q) begin
          w_accept = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (w_rd && (addr_q == LAST_ADDR)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && ((w_occ - {1'b0, w_pop}) == 2'd0)) begin
          w_finish = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= MODE_PASS;
      key_q      <= '0;
      inflight_q <= 1'b0;
      sof_tag_q  <= 1'b0;
      eol_tag_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= w_rd;
      done_q     <= w_finish;
      if (w_accept) begin
        mode_q <= bus.mode;
        key_q  <= bus.key_colour;
        addr_q <= '0;
        x_q    <= '0;
        y_q    <= '0;
        busy_q <= 1'b1;
      end else if (w_finish) begin
        busy_q <= 1'b0;
      end
      if (w_rd) begin
        sof_tag_q <= (x_q == '0) && (y_q == '0);
        eol_tag_q <= (x_q == LAST_X);
        addr_q    <= addr_q + 1'b1;
        if (x_q == LAST_X) begin
          x_q <= '0;
          y_q <= (y_q == LAST_Y) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  assign w_fifo_wdata = {apply_mask(mode_q, bus.img_data, bus.mask_data, key_q),
                         sof_tag_q, eol_tag_q};

  pixel_skid_fifo #(
    .DATA_W (14)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (w_fifo_wdata),
    .pop_i   (w_pop),
    .data_o  (w_fifo_rdata),
    .valid_o (w_fifo_valid),
    .count_o (w_occ)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = w_rd;
  assign bus.out_valid = w_fifo_valid;
  assign bus.out_pixel = w_fifo_rdata[13:2];
  assign bus.out_sof   = w_fifo_rdata[1];
  assign bus.out_eol   = w_fifo_rdata[0];

endmodule
`default_nettype wire

// File: tb/tb_mask_pixel_source.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mask_pixel_source : randomized stimulus against a queue-based frame model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mask_pixel_source;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic clk;
  logic rst_n;

  mask_pixel_source_if #(.ADDR_W(AW)) bus ();

  mask_pixel_source #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [11:0] img_mem  [16];
  bit          mask_mem [16];
  logic [11:0] pix_log  [64];
  bit          sof_log  [64];
  bit          eol_log  [64];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.img_data  <= img_mem[bus.mem_addr];
      bus.mask_data <= mask_mem[bus.mem_addr];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pix(input logic [1:0] md, input logic [11:0] img,
                                          input bit m, input logic [11:0] key);
    case (md)
      2'd1:    return m ? img : 12'h000;
      2'd2:    return m ? ~img : img;
      2'd3:    return m ? key : img;
      default: return img;
    endcase
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic [13:0] exp_q [$];
  bit          busy_exp, done_exp, prev_stall;
  logic [13:0] prev_word;
  int          pend, reads, cyc, valid_due;

  always @(negedge clk) begin : p_compare
    bit hs, busy_n, done_n;
    if (!rst_n) begin
      exp_q.delete();
      busy_exp   = 0;
      done_exp   = 0;
      prev_stall = 0;
      pend       = 0;
      reads      = 0;
      valid_due  = -10;
    end else begin
      cyc++;
      hs     = bus.out_valid && bus.out_ready;
      busy_n = busy_exp;
      done_n = 0;
      check("busy", bus.busy, busy_exp);
      check("done", bus.done, done_exp);
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        check("pixel", bus.out_pixel, exp_q[0][13:2]);
        check("sof", bus.out_sof, exp_q[0][1]);
        check("eol", bus.out_eol, exp_q[0][0]);
      end
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_word", {bus.out_pixel, bus.out_sof, bus.out_eol}, prev_word);
      end
      if (cyc == valid_due - 1) check("latency_early", bus.out_valid, 0);
      if (cyc == valid_due)     check("latency", bus.out_valid, 1);
      check("no_overflow", pend <= 2, 1);
      if (bus.mem_rd) begin
        check("rd_in_frame", busy_exp, 1);
        check("rd_addr", bus.mem_addr, reads);
        check("rd_count", reads < N, 1);
        check("rd_room", (pend - int'(hs)) < 2, 1);
        reads++;
        pend++;
      end
      if (hs && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pend--;
        if (exp_q.size() == 0) begin
          done_n = 1;
          busy_n = 0;
        end
      end
      if (bus.start && !busy_exp && !done_exp) begin
        for (int a = 0; a < N; a++)
          exp_q.push_back({ref_pix(bus.mode, img_mem[a], mask_mem[a], bus.key_colour),
                           a == 0, (a % W) == W - 1});
        busy_n    = 1;
        reads     = 0;
        valid_due = cyc + 3;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_pixel, bus.out_sof, bus.out_eol};
      busy_exp   = busy_n;
      done_exp   = done_n;
    end
  end

  // ---------------- stimulus ----------------
  // rmode: 0 ready=1, 1 random ready, 2 stall 20 cycles at last pixel,
  //        3 extra start mid-frame, 4 start in done cycle, 5 reset at pixel 3
  task automatic run_frame(input logic [1:0] md, input logic [11:0] key, input int rmode,
                           output int first_valid, output int done_at, output int npix);
    int c, stall;
    bit aborted;
    first_valid = -1;
    done_at     = -1;
    npix        = 0;
    stall       = 0;
    aborted     = 0;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.mode       = md;
    bus.key_colour = key;
    bus.out_ready  = (rmode == 1) ? 1'($urandom % 2) : 1'b1;
    c = 0;
    while (c < 300) begin
      @(posedge clk); #1;
      c++;
      bus.start = ((rmode == 3) && (c == 5)) || ((rmode == 4) && (c == 11));
      if (rmode == 1) begin
        bus.out_ready = 1'($urandom % 2);
      end else if (rmode == 2 && npix == N - 1 && stall < 20) begin
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (rmode == 5 && npix == 3) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_pixel", bus.out_pixel, 0);
        check("rst_sof", bus.out_sof, 0);
        check("rst_eol", bus.out_eol, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        aborted = 1;
        break;
      end
      if (bus.out_valid && first_valid < 0) first_valid = c;
      if (bus.out_valid && bus.out_ready) begin
        pix_log[npix] = bus.out_pixel;
        sof_log[npix] = bus.out_sof;
        eol_log[npix] = bus.out_eol;
        npix++;
      end
      if (bus.done) begin
        done_at = c;
        break;
      end
    end
    if (!aborted && done_at < 0) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got no done, expected done within 300 cycles");
    end
    if (rmode != 5) begin
      check("busy_at_done", bus.busy, 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, da, np;
    logic [11:0] e0, e1;
    rst_n          = 1'b1;
    bus.start      = 1'b0;
    bus.mode       = 2'd0;
    bus.key_colour = 12'h000;
    bus.out_ready  = 1'b0;
    bus.img_data   = 12'h000;
    bus.mask_data  = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_mem_rd", bus.mem_rd, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_pixel", bus.out_pixel, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // geometry / pass-through
    for (int a = 0; a < 16; a++) begin
      img_mem[a]  = 12'(a);
      mask_mem[a] = 1'b0;
    end
    run_frame(2'd0, 12'h000, 0, fv, da, np);
    check("pass_first_valid", fv, 3);
    check("pass_done_cycle", da, 11);
    check("pass_count", np, N);
    for (int i = 0; i < N; i++) begin
      check("pass_pixel", pix_log[i], i);
      check("pass_sof", sof_log[i], i == 0);
      check("pass_eol", eol_log[i], (i == 3) || (i == 7));
    end

    // mask operations
    for (int a = 0; a < 16; a++) begin
      img_mem[a]  = 12'hF0A;
      mask_mem[a] = a[0];
    end
    for (int md = 1; md < 4; md++) begin
      run_frame(2'(md), 12'h123, 0, fv, da, np);
      case (md)
        1:       begin e0 = 12'h000; e1 = 12'hF0A; end
        2:       begin e0 = 12'hF0A; e1 = 12'h0F5; end
        default: begin e0 = 12'hF0A; e1 = 12'h123; end
      endcase
      check("mask_even", pix_log[0], e0);
      check("mask_odd", pix_log[1], e1);
      check("mask_last", pix_log[7], e1);
    end

    // random data under random backpressure
    for (int f = 0; f < 6; f++) begin
      for (int a = 0; a < 16; a++) begin
        img_mem[a]  = 12'($urandom);
        mask_mem[a] = 1'($urandom % 2);
      end
      run_frame(2'($urandom % 4), 12'($urandom), 1, fv, da, np);
      check("random_count", np, N);
    end

    // stall at the last pixel
    run_frame(2'd2, 12'h000, 2, fv, da, np);
    check("stall_count", np, N);
    check("stall_done_cycle", da, 31);

    // start while busy
    run_frame(2'd0, 12'h000, 3, fv, da, np);
    check("restart_count", np, N);
    check("restart_done_cycle", da, 11);

    // start coinciding with done
    run_frame(2'd3, 12'h456, 4, fv, da, np);
    check("done_start_count", np, N);
    repeat (4) @(posedge clk);
    #1;
    check("done_start_ignored", bus.busy, 0);

    // reset mid-frame, then a clean frame
    for (int a = 0; a < 16; a++) begin
      img_mem[a]  = 12'(a + 12'h100);
      mask_mem[a] = 1'b0;
    end
    run_frame(2'd0, 12'h000, 5, fv, da, np);
    check("abort_no_done", da, -1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(2'd0, 12'h000, 0, fv, da, np);
    check("after_reset_pixel0", pix_log[0], 12'h100);
    check("after_reset_sof", sof_log[0], 1);
    check("after_reset_count", np, N);
    check("after_reset_done", da, 11);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
